// File: rtl/alu_pkg.sv
// Shared ALU package: widths, opcode encoding and shift-amount helper.
// Imported by alu_core and alu_lzc.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] OP_ADDU = 4'd0;
  localparam logic [ALUOP_W-1:0] OP_ADD  = 4'd1;
  localparam logic [ALUOP_W-1:0] OP_SUBU = 4'd2;
  localparam logic [ALUOP_W-1:0] OP_SUB  = 4'd3;
  localparam logic [ALUOP_W-1:0] OP_AND  = 4'd4;
  localparam logic [ALUOP_W-1:0] OP_OR   = 4'd5;
  localparam logic [ALUOP_W-1:0] OP_XOR  = 4'd6;
  localparam logic [ALUOP_W-1:0] OP_NOR  = 4'd7;
  localparam logic [ALUOP_W-1:0] OP_SLT  = 4'd8;
  localparam logic [ALUOP_W-1:0] OP_SLTU = 4'd9;
  localparam logic [ALUOP_W-1:0] OP_SLL  = 4'd10;
  localparam logic [ALUOP_W-1:0] OP_SRL  = 4'd11;
  localparam logic [ALUOP_W-1:0] OP_SRA  = 4'd12;
  localparam logic [ALUOP_W-1:0] OP_LUI  = 4'd13;
  localparam logic [ALUOP_W-1:0] OP_CLZ  = 4'd14;
  localparam logic [ALUOP_W-1:0] OP_CLO  = 4'd15;

  function automatic int shamt_w();
    return $clog2(DATA_W);
  endfunction

  localparam int SHAMT_W = shamt_w();
  localparam int CNT_W   = SHAMT_W + 1;

endpackage

// File: rtl/alu_lzc.sv
// Leading-zero counter: returns 0..32 for a 32-bit word.
// Only instantiated when ALU_CLZ_EN is defined.
module alu_lzc
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  output logic [CNT_W-1:0]  cnt
);

  // Scan from LSB up so the highest set bit wins.
  always_comb begin
    cnt = CNT_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (din[i]) cnt = CNT_W'(DATA_W - 1 - i);
    end
  end

endmodule

// File: rtl/alu_core.sv
// 32-bit EXE-stage ALU with sticky signed-overflow flag.
// Define ALU_CLZ_EN to enable the CLZ/CLO opcodes.
module alu_core
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  scr0,
  input  logic [DATA_W-1:0]  scr1,
  input  logic [ALUOP_W-1:0] aluop,
  output logic [DATA_W-1:0]  aluso,
  output logic               overflow,
  output logic               ovf_sticky
);

  logic [DATA_W-1:0]  sum;
  logic [DATA_W-1:0]  diff;
  logic [SHAMT_W-1:0] sh;
  logic               add_ovf;
  logic               sub_ovf;
  logic               lt_s;
  logic               lt_u;

  assign sum  = scr0 + scr1;
  assign diff = scr0 - scr1;
  assign sh   = scr0[SHAMT_W-1:0];
  assign lt_s = $signed(scr0) < $signed(scr1);
  assign lt_u = scr0 < scr1;

  assign add_ovf = (scr0[DATA_W-1] == scr1[DATA_W-1])
                 & (sum[DATA_W-1] != scr0[DATA_W-1]);
  assign sub_ovf = (scr0[DATA_W-1] != scr1[DATA_W-1])
                 & (diff[DATA_W-1] != scr0[DATA_W-1]);

`ifdef ALU_CLZ_EN
  logic [CNT_W-1:0] clz;
  logic [CNT_W-1:0] clo;

  alu_lzc u_clz (.din(scr0),  .cnt(clz));
  alu_lzc u_clo (.din(~scr0), .cnt(clo));
`endif

  always_comb begin
    aluso    = '0;
    overflow = 1'b0;
    case (aluop)
      OP_ADDU: aluso = sum;
      OP_ADD: begin
        aluso    = sum;
        overflow = add_ovf;
      end
      OP_SUBU: aluso = diff;
      OP_SUB: begin
        aluso    = diff;
        overflow = sub_ovf;
      end
      OP_AND:  aluso = scr0 & scr1;
      OP_OR:   aluso = scr0 | scr1;
      OP_XOR:  aluso = scr0 ^ scr1;
      OP_NOR:  aluso = ~(scr0 | scr1);
      OP_SLT:  aluso = {{(DATA_W-1){1'b0}}, lt_s};
      OP_SLTU: aluso = {{(DATA_W-1){1'b0}}, lt_u};
      OP_SLL:  aluso = scr1 << sh;
      OP_SRL:  aluso = scr1 >> sh;
      OP_SRA:  aluso = $signed(scr1) >>> sh;
      OP_LUI:  aluso = {scr1[15:0], 16'h0000};
`ifdef ALU_CLZ_EN
      OP_CLZ:  aluso = {{(DATA_W-CNT_W){1'b0}}, clz};
      OP_CLO:  aluso = {{(DATA_W-CNT_W){1'b0}}, clo};
`endif
      default: aluso = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)           ovf_sticky <= 1'b0;
    else if (overflow) ovf_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core.
// Build with +define+ALU_CLZ_EN to exercise CLZ/CLO.
module tb_alu_core;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] scr0;
  logic [31:0] scr1;
  logic [3:0]  aluop;
  logic [31:0] aluso;
  logic        overflow;
  logic        ovf_sticky;

  int checks   = 0;
  int failures = 0;

  alu_core dut (
    .clk(clk),
    .rst(rst),
    .scr0(scr0),
    .scr1(scr1),
    .aluop(aluop),
    .aluso(aluso),
    .overflow(overflow),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    aluop = op;
    scr0  = a;
    scr1  = b;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(OP_ADDU, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      $display("FAIL reset_sticky got=%b exp=0", ovf_sticky);
      failures++;
    end
    checks++;
    if (aluso !== 32'h0 || overflow !== 1'b0) begin
      $display("FAIL reset_addu0 got=%h/%b exp=0/0", aluso, overflow);
      failures++;
    end
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    logic [3:0]  op [6];
    logic [31:0] a  [6];
    logic [31:0] b  [6];
    logic [31:0] ev [6];
    logic        eo [6];
    op = '{OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_ADD, OP_SUB};
    a  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000,
           32'h80000000, 32'h00000005, 32'h00000003};
    b  = '{32'h1, 32'h1, 32'h1, 32'h1, 32'hFFFFFFFD, 32'h5};
    ev = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF,
           32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE};
    eo = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      drive(op[i], a[i], b[i]);
      checks++;
      if (aluso !== ev[i] || overflow !== eo[i]) begin
        $display("FAIL addsub[%0d] got=%h/%b exp=%h/%b",
                 i, aluso, overflow, ev[i], eo[i]);
        failures++;
      end
      if (i == 0) begin
        @(posedge clk);
        #1;
        checks++;
        if (ovf_sticky !== 1'b1) begin
          $display("FAIL sticky_set got=%b exp=1", ovf_sticky);
          failures++;
        end
        @(negedge clk);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ovf_sticky !== 1'b1) begin
      $display("FAIL sticky_hold got=%b exp=1", ovf_sticky);
      failures++;
    end
  endtask

  task automatic test_logic_cmp();
    logic [3:0]  op [7];
    logic [31:0] a  [7];
    logic [31:0] b  [7];
    logic [31:0] ev [7];
    op = '{OP_SLT, OP_SLTU, OP_NOR, OP_LUI, OP_AND, OP_OR, OP_XOR};
    a  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hDEAD0000,
           32'hF0F01234, 32'hF0F01234, 32'hF0F01234};
    b  = '{32'h1, 32'h1, 32'h0, 32'h00001234,
           32'h0FF05678, 32'h0FF05678, 32'h0FF05678};
    ev = '{32'h1, 32'h0, 32'hFFFFFFFF, 32'h12340000,
           32'h00F01230, 32'hFFF0567C, 32'hFF00444C};
    for (int i = 0; i < 7; i++) begin
      drive(op[i], a[i], b[i]);
      checks++;
      if (aluso !== ev[i] || overflow !== 1'b0) begin
        $display("FAIL logic[%0d] got=%h/%b exp=%h/0",
                 i, aluso, overflow, ev[i]);
        failures++;
      end
    end
  endtask

  task automatic test_shift();
    logic [3:0]  op [6];
    logic [31:0] a  [6];
    logic [31:0] ev [6];
    op = '{OP_SRA, OP_SRL, OP_SLL, OP_SRA, OP_SRL, OP_SLL};
    a  = '{32'h24, 32'h24, 32'h24, 32'h0, 32'h0, 32'h0};
    ev = '{32'hF8000000, 32'h08000000, 32'h00000010,
           32'h80000001, 32'h80000001, 32'h80000001};
    for (int i = 0; i < 6; i++) begin
      drive(op[i], a[i], 32'h80000001);
      checks++;
      if (aluso !== ev[i] || overflow !== 1'b0) begin
        $display("FAIL shift[%0d] got=%h/%b exp=%h/0",
                 i, aluso, overflow, ev[i]);
        failures++;
      end
    end
  endtask

  task automatic test_rst_priority();
    @(negedge clk);
    drive(OP_ADD, 32'h7FFFFFFF, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      $display("FAIL rst_wins got=%b exp=0", ovf_sticky);
      failures++;
    end
    @(negedge clk);
    rst = 1'b0;
    drive(OP_ADDU, 32'h0, 32'h0);
    checks++;
    if (aluso !== 32'h0 || overflow !== 1'b0) begin
      $display("FAIL idle_addu got=%h/%b exp=0/0", aluso, overflow);
      failures++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      $display("FAIL sticky_idle got=%b exp=0", ovf_sticky);
      failures++;
    end
  endtask

  task automatic test_clz();
    logic [3:0]  op [4];
    logic [31:0] a  [4];
    logic [31:0] ev [4];
    op = '{OP_CLZ, OP_CLZ, OP_CLO, OP_CLO};
    a  = '{32'h00010000, 32'h0, 32'hFFFFFFFF, 32'hF0000000};
`ifdef ALU_CLZ_EN
    ev = '{32'd15, 32'd32, 32'd32, 32'd4};
`else
    ev = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(op[i], a[i], 32'h12345678);
      checks++;
      if (aluso !== ev[i] || overflow !== 1'b0) begin
        $display("FAIL clz[%0d] got=%h/%b exp=%h/0",
                 i, aluso, overflow, ev[i]);
        failures++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_cmp();
    test_shift();
    test_rst_priority();
    test_clz();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 32-bit integer ALU for the EXE-up stage.
- Computes arithmetic, logic, compare, shift and LUI results combinationally from two operands and an opcode.
- Result also serves as branch-target adder output and as the ALU result forwarded to later stages.
- A small clocked sticky flag records any signed-overflow event since reset for debug/trap bookkeeping.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- ALUOP_W, 4, opcode width; must match the shared package.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- scr0  input  32  operand 0; also the shift amount (bits [4:0]) for shifts.
- scr1  input  32  operand 1; also the shifted value for shifts and the immediate for LUI.
- aluop  input  4  operation select (package encoding).
- aluso  output  32  combinational result.
- overflow  output  1  combinational signed-overflow flag.
- ovf_sticky  output  1  registered; set once any overflow has occurred since reset.

Behaviour:
- aluso and overflow are purely combinational: zero latency, valid in the same cycle as the inputs. Reset does not affect them.
- Opcode encoding:
  - 0 ADDU: scr0+scr1, wraps mod 2^32.
  - 1 ADD: same sum as ADDU.
  - 2 SUBU: scr0-scr1, wraps.
  - 3 SUB: same difference as SUBU.
  - 4 AND, 5 OR, 6 XOR, 7 NOR: bitwise.
  - 8 SLT: 1 if signed scr0<scr1, else 0 (zero-extended).
  - 9 SLTU: same comparison, unsigned.
  - 10 SLL: scr1 << scr0[4:0].
  - 11 SRL: scr1 >> scr0[4:0], logical.
  - 12 SRA: arithmetic right shift of scr1 by scr0[4:0].
  - 13 LUI: {scr1[15:0],16'h0000}.
  - 14 CLZ, 15 CLO: see Optional Feature.
- Shift amounts use only scr0[4:0]; upper bits are ignored. Shift by 0 returns scr1 unchanged.
- overflow=1 only for ADD or SUB when the signed result overflows.
  - ADD: operands share a sign and the sum's sign differs.
  - SUB: operands differ in sign and the result's sign differs from scr0.
  - overflow is 0 for every other opcode, including ADDU/SUBU.
  - aluso still carries the wrapped value on overflow.
- aluop=0 (ADDU) is the value a cleared upstream register presents; with zero operands, aluso=0 and overflow=0.
- Any opcode not implemented in the current build gives aluso=0, overflow=0.
- ovf_sticky:
  - Reset value 0.
  - At each posedge clk: if rst, clear to 0; else if overflow, set to 1; else hold.
  - rst wins over a simultaneous overflow.
  - Cleared only by rst.

Optional Feature:
- Macro ALU_CLZ_EN.
- Defined:
  - CLZ: aluso = count of leading zero bits of scr0, 0..32; scr0=0 gives 32.
  - CLO: aluso = count of leading one bits of scr0; scr0=32'hFFFFFFFF gives 32.
  - Both are zero-extended and give overflow=0.
- Undefined: opcodes 14 and 15 give aluso=0, overflow=0, and no counter logic is instantiated.

Decomposition:
- Shared package alu_pkg: ALUOP_W, DATA_W, the named opcode constants 0..15, and a helper for the shift-amount width (5).
- One natural sub-module, alu_lzc: 32-bit leading-zero counter with a 6-bit result. CLO reuses it by feeding ~scr0. It is instantiated only under ALU_CLZ_EN.

Test Plan:
- ADD with scr0=32'h7FFFFFFF, scr1=1 -> aluso=32'h80000000, overflow=1; next posedge ovf_sticky=1 and stays 1 until rst.
- ADDU with the same operands -> aluso=32'h80000000, overflow=0. SUB with scr0=32'h80000000, scr1=1 -> aluso=32'h7FFFFFFF, overflow=1.
- Compares with scr0=32'hFFFFFFFF, scr1=1:
  - SLT -> 1.
  - SLTU -> 0.
  - NOR of 0 and 0 -> 32'hFFFFFFFF.
  - LUI with scr1=32'h00001234 -> 32'h12340000.
- Shifts with scr1=32'h80000001:
  - scr0=32'h00000024 (low bits 4): SRA -> 32'hF8000000, SRL -> 32'h08000000, SLL -> 32'h00000010.
  - scr0=0: all three return scr1 unchanged.
- rst asserted in the same cycle as an ADD overflow -> ovf_sticky=0 after the edge. After rst deasserts with ADDU operands 0,0 -> aluso=0, overflow=0, ovf_sticky stays 0.
- CLZ/CLO:
  - With ALU_CLZ_EN: CLZ of 32'h00010000 -> 15; CLZ of 0 -> 32; CLO of 32'hFFFFFFFF -> 32; CLO of 32'hF0000000 -> 4.
  - Without ALU_CLZ_EN: opcodes 14 and 15 -> aluso=0, overflow=0.
